fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
- Single-clock, fully parametrised FIFO: next generation of the team's FIFO block.
- Adds arbitrary power-of-two depth, configurable data width, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and synchronous flush.
- Used as the general-purpose buffer between same-clock producer/consumer pipelines.
- Optional first-word-fall-through (FWFT) read mode.

Parameters:
- DATA_WIDTH, 8, bits per entry (>=1).
- FIFO_SIZE, 32, number of entries; power of two, >=4.
- AFULL_THRESH, FIFO_SIZE-4, almost_full asserts when count >= this value (1..FIFO_SIZE).
- AEMPTY_THRESH, 4, almost_empty asserts when count <= this value (0..FIFO_SIZE-1).
- CNT_WIDTH, $clog2(FIFO_SIZE)+1, localparam; width of count.

Ports:
- clock  input  1  single clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of contents and flags.
- data_in  input  DATA_WIDTH  write data.
- write_en  input  1  write request.
- fifo_full  output  1  count == FIFO_SIZE.
- almost_full  output  1  count >= AFULL_THRESH.
- read_en  input  1  read request.
- data_out  output  DATA_WIDTH  read data.
- data_valid  output  1  data_out holds a valid popped/head word.
- fifo_empty  output  1  count == 0.
- almost_empty  output  1  count <= AEMPTY_THRESH.
- count  output  CNT_WIDTH  current occupancy, 0..FIFO_SIZE.
- overflow  output  1  sticky: write attempted while full.
- underflow  output  1  sticky: read attempted while empty.

Behaviour:
- Reset (async assert, sync release): pointers = 0, count = 0, data_out = 0, data_valid = 0, overflow = 0, underflow = 0. Therefore fifo_empty = 1, almost_empty = 1, fifo_full = 0, almost_full = 0. Memory contents are not reset.
- Pointers: wr_ptr and rd_ptr are $clog2(FIFO_SIZE) bits and wrap naturally from FIFO_SIZE-1 to 0. count is a separate CNT_WIDTH register.
- Accepted write: write_en && !fifo_full. The entry at wr_ptr is stored and wr_ptr increments.
- Accepted read: read_en && !fifo_empty. rd_ptr increments.
- Full/empty gating uses registered state at the start of the cycle.
- count update: +1 on write only, -1 on read only, unchanged on simultaneous accepted write and read or when neither is accepted.
- Write while full: the word is dropped, state is unchanged and overflow is set. This holds even if read_en is also asserted; no write-through when full.
- Read while empty: no pointer change and underflow is set. This holds even if write_en is also asserted.
- Normal mode read latency: data_out <= mem[rd_ptr] on an accepted read, with data_valid = 1 the next cycle. data_valid = 0 on any cycle following no accepted read. data_out holds its last value when no read is accepted.
- Flags fifo_full, fifo_empty, almost_full and almost_empty are decoded from the count register, so there are no combinational paths from inputs.
- flush: next cycle has pointers = 0, count = 0, data_valid = 0, overflow = 0, underflow = 0; data_out is held. flush has priority over a write or read in the same cycle, and those requests are discarded without setting error flags.
- Reset mid-operation: immediate return to reset state; any in-flight read data is lost.

Optional Feature:
- Macro: FIFO_FWFT_EN.
- When defined, first-word-fall-through mode applies:
  - data_out always presents mem[rd_ptr] (head entry).
  - data_valid = !fifo_empty.
  - An accepted read_en pops the head, and the next entry appears on the following cycle.
  - A word written into an empty FIFO appears on data_out, with data_valid = 1, the cycle after the write.
  - Overflow/underflow/flush rules are unchanged.
- When undefined, the registered 1-cycle-latency read described above applies.

Test Plan:
- Setup for all cases: DATA_WIDTH=8, FIFO_SIZE=8, AFULL_THRESH=6, AEMPTY_THRESH=1.
- Fill/drain: after reset, write 0x01..0x08 -> count = 8, fifo_full = 1, almost_full from 6th write. Read 8 times -> data_out = 0x01..0x08 one cycle after each read_en, data_valid pulses, fifo_empty = 1 at end.
- Wrap-around: write 5, read 5, write 8 (0xA0..0xA7), read 8 -> order preserved across pointer wrap, count returns to 0.
- Simultaneous: with count = 3, assert write_en + read_en for 10 cycles -> count stays 3, output order matches input order.
- Errors: at full, write 0xFF with read_en = 1 -> 0xFF dropped, overflow = 1, count 8 -> 7. At empty, read_en = 1 -> underflow = 1, data_valid = 0. Flush -> both flags cleared, count = 0.
- Flush priority: count = 4, assert flush + write_en + read_en -> next cycle count = 0, no data_valid, no error flags; a subsequent write/read returns the new word.
- Async reset: assert reset mid-stream between clock edges -> outputs go to reset values immediately; after release, FIFO operates normally. With FIFO_FWFT_EN: a single write of 0x5A into empty FIFO -> data_out = 0x5A, data_valid = 1 on next cycle, with no read_en.

Source files
------------

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock parametrised FIFO with count, almost flags, sticky errors and flush; define FIFO_FWFT_EN for first-word-fall-through reads
module fifo_sync_param #(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_SIZE     = 32,
    parameter int AFULL_THRESH  = FIFO_SIZE - 4,
    parameter int AEMPTY_THRESH = 4,
    localparam int CNT_WIDTH    = $clog2(FIFO_SIZE) + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write_en,
    output logic                  fifo_full,
    output logic                  almost_full,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  fifo_empty,
    output logic                  almost_empty,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int AW = $clog2(FIFO_SIZE);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(FIFO_SIZE);
    localparam logic [CNT_WIDTH-1:0] AF_CNT   = CNT_WIDTH'(AFULL_THRESH);
    localparam logic [CNT_WIDTH-1:0] AE_CNT   = CNT_WIDTH'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_SIZE];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  full, empty, wr_acc, rd_acc;

    assign full         = count_q == FULL_CNT;
    assign empty        = count_q == '0;
    assign wr_acc       = write_en && !full && !flush;
    assign rd_acc       = read_en && !empty && !flush;
    assign fifo_full    = full;
    assign fifo_empty   = empty;
    assign almost_full  = count_q >= AF_CNT;
    assign almost_empty = count_q <= AE_CNT;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // next-state for pointers, occupancy and sticky error flags; flush wins over everything
    always_comb begin
        wr_ptr_d = flush ? '0 : wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = flush ? '0 : rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = flush ? '0 : (wr_acc && !rd_acc) ? count_q + CNT_WIDTH'(1) :
                   (rd_acc && !wr_acc) ? count_q - CNT_WIDTH'(1) : count_q;
        ovf_d    = !flush && (ovf_q || (write_en && full));
        unf_d    = !flush && (unf_q || (read_en && empty));
    end

    // storage array is not reset; only accepted writes touch it
    always_ff @(posedge clock) begin
        if (wr_acc) mem_q[wr_ptr_q] <= data_in;
    end

    // control state registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

`ifdef FIFO_FWFT_EN
    assign data_out   = mem_q[rd_ptr_q];
    assign data_valid = !empty;
`else
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  dvalid_q;

    assign data_out   = dout_q;
    assign data_valid = dvalid_q;

    // registered read port: popped word appears one cycle after the accepted read
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            dout_q   <= rd_acc ? mem_q[rd_ptr_q] : dout_q;
            dvalid_q <= rd_acc;
        end
    end
`endif
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed scenarios plus random traffic checked every cycle against a queue model
module tb_fifo_sync_param;
    logic       clock = 1'b0, reset = 1'b1, flush = 1'b0, write_en = 1'b0, read_en = 1'b0;
    logic [7:0] data_in = '0;
    logic       fifo_full, almost_full, data_valid, fifo_empty, almost_empty, overflow, underflow;
    logic [7:0] data_out;
    logic [3:0] count;
    int checks = 0, errors = 0;

    fifo_sync_param #(.DATA_WIDTH(8), .FIFO_SIZE(8), .AFULL_THRESH(6), .AEMPTY_THRESH(1)) dut (
        .clock(clock), .reset(reset), .flush(flush), .data_in(data_in), .write_en(write_en),
        .fifo_full(fifo_full), .almost_full(almost_full), .read_en(read_en), .data_out(data_out),
        .data_valid(data_valid), .fifo_empty(fifo_empty), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [7:0] q[$];
    logic [7:0] m_dout = '0;
    logic       m_dv = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            q.delete(); m_dout = '0; m_dv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        end else if (flush) begin
            q.delete(); m_dv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            automatic bit was_full = q.size() == 8;
            automatic bit was_empty = q.size() == 0;
            m_dv = 1'b0;
            if (write_en && was_full) m_ovf = 1'b1;
            if (read_en && was_empty) m_unf = 1'b1;
            if (read_en && !was_empty) begin m_dout = q.pop_front(); m_dv = 1'b1; end
            if (write_en && !was_full) q.push_back(data_in);
        end
    end

    always @(negedge clock) begin
        chk("count", 32'(count), 32'(q.size()));
        chk("fifo_full", 32'(fifo_full), 32'(q.size() == 8));
        chk("fifo_empty", 32'(fifo_empty), 32'(q.size() == 0));
        chk("almost_full", 32'(almost_full), 32'(q.size() >= 6));
        chk("almost_empty", 32'(almost_empty), 32'(q.size() <= 1));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
        chk("data_valid", 32'(data_valid), 32'(m_dv));
        chk("data_out", 32'(data_out), 32'(m_dout));
    end

    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic f);
        write_en = w; data_in = d; read_en = r; flush = f;
        @(negedge clock);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("reset_empty", 32'(fifo_empty), 32'd1);
        chk("reset_dout", 32'(data_out), 32'd0);
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            chk("fill_afull", 32'(almost_full), 32'(i >= 6));
        end
        chk("fill_count", 32'(count), 32'd8);
        chk("fill_full", 32'(fifo_full), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_data", 32'(data_out), 32'(i));
            chk("drain_valid", 32'(data_valid), 32'd1);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("drain_empty", 32'(fifo_empty), 32'd1);
        chk("drain_valid_low", 32'(data_valid), 32'd0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk("wrap_data", 32'(data_out), 32'(8'hA0 + i));
        end
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
        chk("simul_count", 32'(count), 32'd3);
        chk("simul_last", 32'(data_out), 32'h46);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b1, 1'b0);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd7);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("ovf_dropped", 32'(data_out), 32'h54);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("unf_flag", 32'(underflow), 32'd1);
        chk("unf_valid", 32'(data_valid), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("flush_ovf", 32'(overflow), 32'd0);
        chk("flush_unf", 32'(underflow), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b1);
        chk("fprio_count", 32'(count), 32'd0);
        chk("fprio_valid", 32'(data_valid), 32'd0);
        chk("fprio_errs", 32'({overflow, underflow}), 32'd0);
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fprio_new", 32'(data_out), 32'h3C);
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        write_en = 1'b0; read_en = 1'b1;
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("areset_count", 32'(count), 32'd0);
        chk("areset_empty", 32'(fifo_empty), 32'd1);
        chk("areset_valid", 32'(data_valid), 32'd0);
        chk("areset_dout", 32'(data_out), 32'd0);
        read_en = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        step(1'b1, 8'h99, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_reset", 32'(data_out), 32'h99);
        for (int i = 0; i < 600; i++) begin
            automatic int ph = (i / 100) % 3;
            automatic logic w = $urandom_range(99) < (ph == 0 ? 75 : ph == 1 ? 25 : 50);
            automatic logic r = $urandom_range(99) < (ph == 0 ? 25 : ph == 1 ? 75 : 50);
            step(w, 8'($urandom), r, $urandom_range(49) == 0);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
